// File: rtl/seg_scan_disp_if.sv
// Bus bundle between the register/debug side and the seg_scan_disp display driver.
// The blink request lane exists only when SEG_BLINK_EN is defined.
interface seg_scan_disp_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] d;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en_mask;
    logic                    lz_blank;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink;
`endif
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_out;
    logic                    frame_done;

`ifdef SEG_BLINK_EN
    modport master (output d, dp, en_mask, lz_blank, blink,
                    input  an, seg, dp_out, frame_done);
    modport slave  (input  d, dp, en_mask, lz_blank, blink,
                    output an, seg, dp_out, frame_done);
`else
    modport master (output d, dp, en_mask, lz_blank,
                    input  an, seg, dp_out, frame_done);
    modport slave  (input  d, dp, en_mask, lz_blank,
                    output an, seg, dp_out, frame_done);
`endif
endinterface

// File: rtl/seg_scan_disp.sv
// Multiplexed NUM_DIGITS hex 7-segment scanner with per-frame input snapshot, masking,
// decimal points and leading-zero blanking. Define SEG_BLINK_EN to add per-digit blinking.
module seg_scan_disp #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    seg_scan_disp_if.slave   bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    wrap;
    logic                    frame_done_q;

    logic [4*NUM_DIGITS-1:0] sh_d;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;

    logic [3:0]              nib;
    logic                    upper_zero;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    // Prescaler, digit index and the once-per-frame snapshot of the display inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt          <= '0;
            idx          <= '0;
            frame_done_q <= 1'b0;
            sh_d         <= '0;
            sh_dp        <= '0;
            sh_en        <= '0;
            sh_lz        <= 1'b0;
        end else begin
            frame_done_q <= wrap;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (wrap) begin
                sh_d  <= bus.d;
                sh_dp <= bus.dp;
                sh_en <= bus.en_mask;
                sh_lz <= bus.lz_blank;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] sh_blink;
    logic [FW-1:0]         fcnt;
    logic                  blink_phase;

    // Phase flips on the same edge that loads a new frame, so a frame never changes phase midway
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_blink    <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b1;
        end else if (wrap) begin
            sh_blink <= bus.blink;
            if (fcnt == FCNT_MAX) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end
`endif

    always_comb begin
        nib        = sh_d[4*int'(idx) +: 4];
        upper_zero = ((sh_d >> (4*int'(idx))) == '0);
        blank      = !sh_en[idx] || (sh_lz && upper_zero && (idx != '0));
`ifdef SEG_BLINK_EN
        blank      = blank || (!blink_phase && sh_blink[idx]);
`endif
        an_nxt     = '0;
        seg_nxt    = '0;
        dp_nxt     = 1'b0;
        if (!blank) begin
            an_nxt  = NUM_DIGITS'(1) << idx;
            seg_nxt = hex7(nib);
            dp_nxt  = sh_dp[idx];
        end
    end

    // All pin drivers load on the same edge so anode, segments and dp cannot skew
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_q  <= '0;
            seg_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an         = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
    assign bus.seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign bus.dp_out     = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Scoreboard bench for seg_scan_disp (NUM_DIGITS=4, DIV=4, ACTIVE_LOW=1): stimulus queues the
// expected frame, a monitor checks every cycle of that frame's four slots after frame_done.
module tb_seg_scan_disp;
    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] an;
        logic [27:0] seg;
        logic [3:0]  dp;
    } frame_t;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;
    frame_t exp_q[$];
    logic   mon_busy;

    seg_scan_disp_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_disp #(
        .NUM_DIGITS (ND),
        .DIV        (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic waitFrameDone(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: frame_done timeout, got 0, expected 1", name);
        end
        #1;
    endtask

    task automatic applyStimulus(input string name, input int delay, input logic [15:0] dv,
                                 input logic [3:0] dpv, input logic [3:0] enm, input logic lz,
                                 input frame_t e);
        repeat (delay) @(negedge clk);
        #1;
        bus.d        = dv;
        bus.dp       = dpv;
        bus.en_mask  = enm;
        bus.lz_blank = lz;
        exp_q.push_back(e);
        $display("[TB] %s: d=%h dp=%b en=%b lz=%b", name, dv, dpv, enm, lz);
        waitFrameDone(name);
    endtask

    // Monitor: every cycle of every slot of a queued frame is compared
    initial begin
        frame_t cur;
        int     n;
        mon_busy = 1'b0;
        n        = 0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (mon_busy) begin
                checkOutput($sformatf("slot%0d", n / 4),
                            {20'd0, bus.an, bus.seg, bus.dp_out},
                            {20'd0, cur.an[4*(n/4) +: 4], cur.seg[7*(n/4) +: 7], cur.dp[n/4]});
                n++;
                if (n == 16) mon_busy = 1'b0;
            end
            if (!mon_busy && rstn && bus.frame_done && exp_q.size() > 0) begin
                cur      = exp_q.pop_front();
                n        = 0;
                mon_busy = 1'b1;
            end
        end
    end

    // frame_done must be a one-cycle pulse every 16 clks, the first one 16 clks after reset release
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                gap = 0;
            end else begin
                gap++;
                if (bus.frame_done) begin
                    checkOutput("frame_gap", gap, 16);
                    gap = 0;
                end
            end
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        rstn         = 1'b0;
        bus.d        = '0;
        bus.dp       = '0;
        bus.en_mask  = '0;
        bus.lz_blank = 1'b0;
`ifdef SEG_BLINK_EN
        bus.blink    = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_an", {28'd0, bus.an}, 32'hF);
        checkOutput("rst_seg", {25'd0, bus.seg}, 32'h7F);
        checkOutput("rst_dp", {31'd0, bus.dp_out}, 32'h1);
        checkOutput("rst_fd", {31'd0, bus.frame_done}, 32'h0);
        rstn = 1'b1;

        applyStimulus("basic_a", 0, 16'h12AF, 4'b0000, 4'hF, 1'b0,
                      '{an: 16'h7BDE, seg: {7'h79, 7'h24, 7'h08, 7'h0E}, dp: 4'hF});
        applyStimulus("basic_b", 0, 16'h12AF, 4'b0000, 4'hF, 1'b0,
                      '{an: 16'h7BDE, seg: {7'h79, 7'h24, 7'h08, 7'h0E}, dp: 4'hF});
        applyStimulus("coherence", 6, 16'h3456, 4'b0000, 4'hF, 1'b0,
                      '{an: 16'h7BDE, seg: {7'h30, 7'h19, 7'h12, 7'h02}, dp: 4'hF});
        applyStimulus("lz_0050", 2, 16'h0050, 4'b0000, 4'hF, 1'b1,
                      '{an: 16'hFFDE, seg: {7'h7F, 7'h7F, 7'h12, 7'h40}, dp: 4'hF});
        applyStimulus("lz_zero", 3, 16'h0000, 4'b0000, 4'hF, 1'b1,
                      '{an: 16'hFFFE, seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dp: 4'hF});
        applyStimulus("mask_dp", 1, 16'h3456, 4'b0011, 4'b0101, 1'b0,
                      '{an: 16'hFBFE, seg: {7'h7F, 7'h19, 7'h7F, 7'h02}, dp: 4'hE});
        applyStimulus("dp_alt", 5, 16'h12AF, 4'b1010, 4'hF, 1'b0,
                      '{an: 16'h7BDE, seg: {7'h79, 7'h24, 7'h08, 7'h0E}, dp: 4'h5});
        applyStimulus("lz_inner", 0, 16'h1000, 4'b0000, 4'hF, 1'b1,
                      '{an: 16'h7BDE, seg: {7'h79, 7'h40, 7'h40, 7'h40}, dp: 4'hF});

        for (int i = 0; i < 100 && (mon_busy || exp_q.size() > 0); i++) @(negedge clk);
        checkOutput("drain", {31'd0, mon_busy}, 32'h0);

        // Mid-slot asynchronous reset while digits are lit
        @(posedge clk);
        #2;
        checkOutput("pre_rst_lit", {31'd0, (bus.an != 4'hF)}, 32'h1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_an", {28'd0, bus.an}, 32'hF);
        checkOutput("mid_rst_seg", {25'd0, bus.seg}, 32'h7F);
        checkOutput("mid_rst_dp", {31'd0, bus.dp_out}, 32'h1);
        checkOutput("mid_rst_fd", {31'd0, bus.frame_done}, 32'h0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        waitFrameDone("post_rst");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
